pwm_ctl_axil_slave: RTL
=======================

Name: pwm_ctl_axil_slave

Overview:
AXI4-Lite responder for the PWM controller register file. It decodes CPU/VIP-master writes and reads into four 32-bit registers and drives a single PWM output from them. It is the slave end of the AXI4-Lite link that the VIP master bench exercises. It sits between the AXI interconnect and the board-level PWM pin.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register, bits [1:0] are ignored.
- CNT_WIDTH, 32, PWM counter width; PERIOD and DUTY are truncated to this width.

Ports:
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
- S_AXI_AWPROT  in  3  ignored
- S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  write-address handshake
- S_AXI_WDATA  in  32  write data
- S_AXI_WSTRB  in  4  byte strobes
- S_AXI_WVALID / S_AXI_WREADY  in/out  1  write-data handshake
- S_AXI_BRESP  out  2  always 2'b00 (OKAY)
- S_AXI_BVALID / S_AXI_BREADY  out/in  1  write-response handshake
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
- S_AXI_ARPROT  in  3  ignored
- S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  read-address handshake
- S_AXI_RDATA  out  32  read data
- S_AXI_RRESP  out  2  always 2'b00
- S_AXI_RVALID / S_AXI_RREADY  out/in  1  read-data handshake
- pwm_o  out  1  PWM output

Behaviour:
- Register map:
  - 0x0 CTRL: [0] enable, [1] invert; other bits read 0.
  - 0x4 PERIOD.
  - 0x8 DUTY.
  - 0xC SCRATCH: R/W, no side effect.
- Reset (ARESET=1 at a rising edge): all registers 0; AWREADY=WREADY=1; ARREADY=1; BVALID=RVALID=0; RDATA=0; counter 0; pwm_o=0. Any handshake in flight is abandoned.
- Write channel:
  - AW and W are captured independently into one-entry holding registers.
  - AWREADY = !aw_held && !BVALID. WREADY = !w_held && !BVALID.
  - On the edge where both address and data become available (captured at the same edge or earlier), the selected register is updated per WSTRB byte lane and BVALID is set.
  - BVALID clears on the BREADY handshake; both holders free on that same edge.
  - At most one write is outstanding. Writes to CTRL bits [31:2] are discarded.
- Read channel:
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is loaded from the decoded register and RVALID is set (1-cycle latency).
  - RVALID and RDATA hold until RREADY; minimum spacing is one read per 2 cycles.
  - Read and write channels operate concurrently.
  - A read of the register written at the same edge returns the old value.
- PWM:
  - When enable=1 and PERIOD≠0: cnt counts 0..PERIOD-1 and wraps to 0.
  - pwm_o is registered: pwm_o = (cnt < DUTY) XOR invert.
  - DUTY ≥ PERIOD gives a constant active level. DUTY = 0 gives a constant inactive level.
  - enable=0 or PERIOD=0: cnt held at 0, pwm_o=0, regardless of invert.
  - A PERIOD write that makes cnt ≥ new PERIOD forces cnt to 0 on the next cycle.
- Comparisons are unsigned, CNT_WIDTH bits.

Optional Feature:
- Macro: PWM_CTL_SHADOW_EN.
- Defined: PERIOD and DUTY writes land in shadow registers. Active copies update only on the cycle cnt wraps to 0, or immediately while enable=0. Reads return the shadow values, giving glitch-free duty changes.
- Undefined: active values equal the registers and changes take effect on the next cycle.

Decomposition:
- Shared package pwm_ctl_pkg holds:
  - Register offset localparams: REG_CTRL, REG_PERIOD, REG_DUTY, REG_SCRATCH.
  - CTRL bit indices: CTRL_EN_BIT, CTRL_INV_BIT.
  - Response constant RESP_OKAY.
- One sub-module, pwm_ctl_core: counter plus compare, and shadow logic when enabled.
- The AXI decode stays in the top level.

Test Plan:
- Reset, then write 0x1, 0x2, 0x3, 0x4 to 0x0–0xC, then read back -> CTRL=0x1 (bits above [1] masked), PERIOD=0x2, DUTY=0x3, SCRATCH=0x4; all responses OKAY.
- W presented 3 cycles before AW, then AW alone -> exactly one BVALID pulse after AW accept; AWREADY/WREADY low while BVALID held with BREADY=0 for 5 cycles.
- WSTRB=4'b0010 with data 0xAABBCCDD to SCRATCH=0x11223344 -> readback 0x1122CC44.
- PERIOD=10, DUTY=3, CTRL=1 -> pwm_o high 3 cycles, low 7, repeating. CTRL=3 -> high 7, low 3. DUTY=12 -> constant 1.
- PERIOD=0 with enable=1 -> pwm_o stays 0. ARESET asserted mid-write (AW accepted, W pending) -> BVALID stays 0, registers are 0 after reset.
- With PWM_CTL_SHADOW_EN: change DUTY 3→6 mid-period -> the current period keeps 3 high cycles and the next period shows 6.

Source files
------------

// File: rtl/pwm_ctl_pkg.sv
// pwm_ctl_pkg: shared constants for the PWM controller register block.
//   - REG_*        : byte offsets of the four 32-bit registers
//   - CTRL_*_BIT   : bit positions inside CTRL
//   - RESP_OKAY    : the only AXI response this block ever returns
//   - apply_wstrb  : merge write data into an old register value per byte lane
package pwm_ctl_pkg;

   localparam logic [3:0] REG_CTRL    = 4'h0;
   localparam logic [3:0] REG_PERIOD  = 4'h4;
   localparam logic [3:0] REG_DUTY    = 4'h8;
   localparam logic [3:0] REG_SCRATCH = 4'hC;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_INV_BIT = 1;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/pwm_ctl_core.sv
// pwm_ctl_core: PWM counter and compare stage.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   enable_i      : run the counter
//   invert_i      : invert the active level
//   period_i      : counter period (register value)
//   duty_i        : number of active cycles per period (register value)
//   pwm_o         : registered PWM output
// Build option PWM_CTL_SHADOW_EN: period_i/duty_i are treated as shadow values
// and copied into the active compare values only when the counter wraps or
// while the counter is idle, so a duty change never cuts a period short.
module pwm_ctl_core
   import pwm_ctl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable_i,
   input  logic                 invert_i,
   input  logic [CNT_WIDTH-1:0] period_i,
   input  logic [CNT_WIDTH-1:0] duty_i,
   output logic                 pwm_o
);

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 pwm_q, pwm_d;
   logic [CNT_WIDTH-1:0] period_act, duty_act;
   logic                 run, wrap;

`ifdef PWM_CTL_SHADOW_EN
   logic [CNT_WIDTH-1:0] period_act_q, period_act_d;
   logic [CNT_WIDTH-1:0] duty_act_q, duty_act_d;

   assign period_act = period_act_q;
   assign duty_act   = duty_act_q;

   // Idle covers enable=0 and also an active period of 0; the latter would
   // otherwise never wrap and could never pick up a new PERIOD.
   always_comb begin
      period_act_d = period_act_q;
      duty_act_d   = duty_act_q;
      if (!run || wrap) begin
         period_act_d = period_i;
         duty_act_d   = duty_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         period_act_q <= '0;
         duty_act_q   <= '0;
      end else begin
         period_act_q <= period_act_d;
         duty_act_q   <= duty_act_d;
      end
   end
`else
   assign period_act = period_i;
   assign duty_act   = duty_i;
`endif

   // ">=" rather than "==" so a PERIOD shrunk below the current count
   // restarts the counter on the next cycle instead of running to overflow.
   always_comb begin
      run   = enable_i && (period_act != '0);
      wrap  = run && (cnt_q >= (period_act - CNT_ONE));
      cnt_d = '0;
      if (run && !wrap) cnt_d = cnt_q + CNT_ONE;
      pwm_d = run && ((cnt_q < duty_act) ^ invert_i);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         pwm_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         pwm_q <= pwm_d;
      end
   end

   assign pwm_o = pwm_q;

endmodule

// File: rtl/pwm_ctl_axil_slave.sv
// pwm_ctl_axil_slave: AXI4-Lite register file driving one PWM output.
// Ports:
//   ACLK, ARESET        : clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*     : write channels (AW and W captured independently)
//   S_AXI_AR*/R*        : read channels (1-cycle read latency)
//   pwm_o               : PWM output from pwm_ctl_core
// Registers: 0x0 CTRL{inv,en}, 0x4 PERIOD, 0x8 DUTY, 0xC SCRATCH.
// Build option PWM_CTL_SHADOW_EN selects shadowed PERIOD/DUTY in the core.
// Handshake: a transfer happens on a rising edge where VALID and READY are both
// high; VALID is never withdrawn by this slave until its handshake completes.
module pwm_ctl_axil_slave
   import pwm_ctl_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 4,
   parameter int CNT_WIDTH          = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            pwm_o
);

   logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [1:0]  aw_word_q, aw_word_d;
   logic [31:0] w_data_q, w_data_d;
   logic [3:0]  w_strb_q, w_strb_d;
   logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  ctrl_q, ctrl_d;
   logic [31:0] period_q, period_d, duty_q, duty_d, scratch_q, scratch_d;

   logic        aw_fire, w_fire, ar_fire, wr_go;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data, ctrl_new;
   logic [3:0]  wr_strb;
   logic        unused_ok;

   assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

   assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
   assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
   assign S_AXI_ARREADY = !rvalid_q;
   assign S_AXI_BVALID  = bvalid_q;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_RVALID  = rvalid_q;
   assign S_AXI_RDATA   = rdata_q;
   assign S_AXI_RRESP   = RESP_OKAY;

   always_comb begin
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
      // Address/data may arrive this edge or be waiting in the holders.
      wr_addr = {(aw_held_q ? aw_word_q : S_AXI_AWADDR[3:2]), 2'b00};
      wr_data = w_held_q ? w_data_q : S_AXI_WDATA;
      wr_strb = w_held_q ? w_strb_q : S_AXI_WSTRB;
      wr_go   = (aw_held_q || aw_fire) && (w_held_q || w_fire) && !bvalid_q;
      ctrl_new = apply_wstrb({30'd0, ctrl_q}, wr_data, wr_strb);

      aw_held_d = aw_held_q;
      aw_word_d = aw_word_q;
      w_held_d  = w_held_q;
      w_data_d  = w_data_q;
      w_strb_d  = w_strb_q;
      bvalid_d  = bvalid_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      ctrl_d    = ctrl_q;
      period_d  = period_q;
      duty_d    = duty_q;
      scratch_d = scratch_q;

      if (aw_fire) begin
         aw_held_d = 1'b1;
         aw_word_d = S_AXI_AWADDR[3:2];
      end
      if (w_fire) begin
         w_held_d = 1'b1;
         w_data_d = S_AXI_WDATA;
         w_strb_d = S_AXI_WSTRB;
      end

      // Holders stay occupied until the response is taken, which is what
      // limits the slave to one outstanding write.
      if (bvalid_q && S_AXI_BREADY) begin
         bvalid_d  = 1'b0;
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
      end else if (wr_go) begin
         bvalid_d = 1'b1;
         case (wr_addr)
            REG_CTRL:   ctrl_d    = {ctrl_new[CTRL_INV_BIT], ctrl_new[CTRL_EN_BIT]};
            REG_PERIOD: period_d  = apply_wstrb(period_q, wr_data, wr_strb);
            REG_DUTY:   duty_d    = apply_wstrb(duty_q, wr_data, wr_strb);
            default:    scratch_d = apply_wstrb(scratch_q, wr_data, wr_strb);
         endcase
      end

      if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
      if (ar_fire) begin
         rvalid_d = 1'b1;
         case ({S_AXI_ARADDR[3:2], 2'b00})
            REG_CTRL:   rdata_d = {30'd0, ctrl_q};
            REG_PERIOD: rdata_d = period_q;
            REG_DUTY:   rdata_d = duty_q;
            default:    rdata_d = scratch_q;
         endcase
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         aw_held_q <= 1'b0;
         aw_word_q <= '0;
         w_held_q  <= 1'b0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid_q  <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         ctrl_q    <= '0;
         period_q  <= '0;
         duty_q    <= '0;
         scratch_q <= '0;
      end else begin
         aw_held_q <= aw_held_d;
         aw_word_q <= aw_word_d;
         w_held_q  <= w_held_d;
         w_data_q  <= w_data_d;
         w_strb_q  <= w_strb_d;
         bvalid_q  <= bvalid_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         ctrl_q    <= ctrl_d;
         period_q  <= period_d;
         duty_q    <= duty_d;
         scratch_q <= scratch_d;
      end
   end

   pwm_ctl_core #(
      .CNT_WIDTH(CNT_WIDTH)
   ) u_core (
      .clk      (ACLK),
      .rst      (ARESET),
      .enable_i (ctrl_q[CTRL_EN_BIT]),
      .invert_i (ctrl_q[CTRL_INV_BIT]),
      .period_i (period_q[CNT_WIDTH-1:0]),
      .duty_i   (duty_q[CNT_WIDTH-1:0]),
      .pwm_o    (pwm_o)
   );

endmodule
